// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus responder: FSM encoding, IO register
// offsets, region decode and the bus-error read pattern.
package mio_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RAM_WAIT = 2'd1,
      ST_RESP     = 2'd2
   } state_t;

   // IO register offsets (addr[3:2]); offset 3 is left unmapped
   localparam logic [1:0] IO_LED = 2'd0;
   localparam logic [1:0] IO_SW  = 2'd1;
   localparam logic [1:0] IO_CNT = 2'd2;

   // Top address nibble that selects block RAM
   localparam logic [3:0] RAM_NIBBLE = 4'h0;

   // Read data returned for unmapped reads when bus errors are reported
   localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      RGN_RAM      = 2'd0,
      RGN_IO       = 2'd1,
      RGN_UNMAPPED = 2'd2
   } region_t;

   // RAM takes priority so a misconfigured IO nibble of 0 cannot shadow it
   function automatic region_t decode_region(input logic [31:0] a,
                                             input logic [3:0]  io_nibble);
      if (a[31:28] == RAM_NIBBLE)
         return RGN_RAM;
      else if ((a[31:28] == io_nibble) && (a[3:2] != 2'd3))
         return RGN_IO;
      else
         return RGN_UNMAPPED;
   endfunction

endpackage

// File: rtl/mio_io_regs.sv
// Peripheral register file behind the MIO responder: LED register,
// two-flop switch synchronizer and a free-running cycle counter.
// Combinational read port, single write strobe.
import mio_pkg::*;

module mio_io_regs (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_we,
   input  logic [1:0]  i_off,
   input  logic [7:0]  i_wdata,
   input  logic [7:0]  i_sw,
   output logic [31:0] o_rdata,
   output logic [7:0]  o_led
);

   logic [7:0]  r_sw_meta;
   logic [7:0]  r_sw_sync;
   logic [7:0]  r_led;
   logic [31:0] r_cnt;

   // Switch synchronizer, LED register and cycle counter (clear wins over increment)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sw_meta <= 8'h00;
         r_sw_sync <= 8'h00;
         r_led     <= 8'h00;
         r_cnt     <= 32'h0;
      end else begin
         r_sw_meta <= i_sw;
         r_sw_sync <= r_sw_meta;
         if (i_we && (i_off == IO_LED))
            r_led <= i_wdata;
         if (i_we && (i_off == IO_CNT))
            r_cnt <= 32'h0;
         else
            r_cnt <= r_cnt + 32'd1;
      end
   end

   // Read mux; the unmapped offset reads as zero
   always_comb begin
      o_rdata = 32'h0;
      case (i_off)
         IO_LED:  o_rdata = {24'h0, r_led};
         IO_SW:   o_rdata = {24'h0, r_sw_sync};
         IO_CNT:  o_rdata = r_cnt;
         default: o_rdata = 32'h0;
      endcase
   end

   assign o_led = r_led;

endmodule

// File: rtl/mio_responder.sv
// MIO bus responder: accepts level-held CPU read/write requests, routes them
// to block RAM (with RAM_LAT wait states) or the IO register file, and
// answers with a one-cycle mio_ready pulse.
// Optional build macro MIO_BUS_ERR_EN adds a bus_err output and returns
// 32'hDEADBEEF on unmapped reads.
import mio_pkg::*;

module mio_responder #(
   parameter int          RAM_AW    = 10,
   parameter int          RAM_LAT   = 2,
   parameter logic [3:0]  IO_NIBBLE = 4'hF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_r,
   input  logic              mem_w,
   input  logic [31:0]       addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              mio_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [7:0]        sw,
`ifdef MIO_BUS_ERR_EN
   output logic              bus_err,
`endif
   output logic [7:0]        led
);

   localparam logic [3:0] LAT_M1 = 4'(RAM_LAT - 1);

`ifdef MIO_BUS_ERR_EN
   localparam logic [31:0] UNMAPPED_RDATA = BUS_ERR_DATA;
`else
   localparam logic [31:0] UNMAPPED_RDATA = 32'h0;
`endif

   state_t            r_state;
   logic [3:0]        r_wait;
   logic              r_wr;
   logic [31:0]       r_cpu_rdata;
   logic              r_mio_ready;
   logic [RAM_AW-1:0] r_ram_addr;
   logic              r_ram_we;
   logic [31:0]       r_ram_wdata;
`ifdef MIO_BUS_ERR_EN
   logic              r_bus_err;
`endif

   logic              w_req;
   logic              w_wr;
   region_t           w_region;
   logic              w_io_we;
   logic [31:0]       w_io_rdata;
   logic              w_unused_addr;

   // Both strobes high counts as a write
   assign w_req    = mem_r | mem_w;
   assign w_wr     = mem_w;
   assign w_region = decode_region(addr, IO_NIBBLE);
   assign w_io_we  = (r_state == ST_IDLE) && w_req && w_wr && (w_region == RGN_IO);
   assign w_unused_addr = ^{addr[27:RAM_AW+2], addr[1:0]};

   mio_io_regs u_io_regs (
      .clk     (clk),
      .reset   (reset),
      .i_we    (w_io_we),
      .i_off   (addr[3:2]),
      .i_wdata (cpu_wdata[7:0]),
      .i_sw    (sw),
      .o_rdata (w_io_rdata),
      .o_led   (led)
   );

   // Request FSM with registered bus and RAM outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_wait      <= 4'd0;
         r_wr        <= 1'b0;
         r_cpu_rdata <= 32'h0;
         r_mio_ready <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_we    <= 1'b0;
         r_ram_wdata <= 32'h0;
`ifdef MIO_BUS_ERR_EN
         r_bus_err   <= 1'b0;
`endif
      end else begin
         r_mio_ready <= 1'b0;
         r_ram_we    <= 1'b0;
`ifdef MIO_BUS_ERR_EN
         r_bus_err   <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  case (w_region)
                     RGN_RAM: begin
                        // Latch the access so later addr/data changes are ignored
                        r_ram_addr  <= addr[RAM_AW+1:2];
                        r_ram_wdata <= cpu_wdata;
                        r_wr        <= w_wr;
                        r_wait      <= LAT_M1;
                        // ram_we must be high during the cycle the counter reads zero
                        r_ram_we    <= w_wr && (LAT_M1 == 4'd0);
                        r_state     <= ST_RAM_WAIT;
                     end
                     RGN_IO: begin
                        r_cpu_rdata <= w_wr ? 32'h0 : w_io_rdata;
                        r_mio_ready <= 1'b1;
                        r_state     <= ST_RESP;
                     end
                     default: begin
                        r_cpu_rdata <= w_wr ? 32'h0 : UNMAPPED_RDATA;
                        r_mio_ready <= 1'b1;
`ifdef MIO_BUS_ERR_EN
                        r_bus_err   <= 1'b1;
`endif
                        r_state     <= ST_RESP;
                     end
                  endcase
               end
            end
            ST_RAM_WAIT: begin
               if (!w_req) begin
                  // CPU withdrew the request: abandon silently
                  r_state <= ST_IDLE;
               end else if (r_wait != 4'd0) begin
                  r_wait   <= r_wait - 4'd1;
                  r_ram_we <= r_wr && (r_wait == 4'd1);
               end else begin
                  r_cpu_rdata <= r_wr ? 32'h0 : ram_rdata;
                  r_mio_ready <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_rdata = r_cpu_rdata;
   assign mio_ready = r_mio_ready;
   assign ram_addr  = r_ram_addr;
   assign ram_we    = r_ram_we;
   assign ram_wdata = r_ram_wdata;
`ifdef MIO_BUS_ERR_EN
   assign bus_err   = r_bus_err;
`endif

endmodule
